// File: rtl/icache_sa.sv
// Set-associative, read-only instruction cache with round-robin replacement.
// Misses fill a whole block through a burst of single-word reads from memory.
module icache_sa #(
  parameter int NSETS = 8,
  parameter int NWAYS = 2,
  parameter int WORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        flush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic [31:0] iload,
  input  logic        iwait
);

  localparam int OFFB = $clog2(WORDS);
  localparam int IDXB = $clog2(NSETS);
  localparam int TAGB = 30 - OFFB - IDXB;
  localparam int OFFW = (WORDS > 1) ? OFFB : 1;
  localparam int WAYW = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam logic [OFFW-1:0] LAST = OFFW'(WORDS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FETCH = 1'b1;

  logic [0:0]      r_state;
  logic [OFFW-1:0] r_cnt;
  logic [29:0]     r_base;
  logic [IDXB-1:0] r_idx;
  logic [TAGB-1:0] r_ltag;
  logic [NWAYS-1:0] r_valid [NSETS];
  logic [WAYW-1:0]  r_ptr   [NSETS];
  logic [TAGB-1:0]  r_tag   [NSETS][NWAYS];
  logic [31:0]      r_data  [NSETS][NWAYS][WORDS];
  logic [31:0]      r_fill  [WORDS];

  logic [29:0]      w_waddr;
  logic [OFFW-1:0]  w_woff;
  logic [IDXB-1:0]  w_idx;
  logic [TAGB-1:0]  w_tag;
  logic [NWAYS-1:0] w_match;
  logic [31:0]      w_way_word [NWAYS];
  logic [31:0]      w_hit_word;
  logic [WAYW-1:0]  w_victim;
  logic             w_any_inv;
  logic             w_idle;
  logic             w_start;
  logic             w_install;
  logic             w_unused;

  assign w_waddr  = imemaddr[31:2];
  assign w_woff   = OFFW'(w_waddr & 30'(WORDS - 1));
  assign w_idx    = IDXB'(w_waddr >> OFFB);
  assign w_tag    = TAGB'(w_waddr >> (OFFB + IDXB));
  assign w_unused = ^imemaddr[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NWAYS; gi++) begin : g_way
      assign w_match[gi]    = r_valid[w_idx][gi] && (r_tag[w_idx][gi] == w_tag);
      assign w_way_word[gi] = w_match[gi] ? r_data[w_idx][gi][w_woff] : 32'd0;
    end
  endgenerate

  // Tags are unique within a set, so OR-ing the gated way words selects the hit.
  always_comb begin
    w_hit_word = 32'd0;
    for (int w = 0; w < NWAYS; w++) begin
      w_hit_word = w_hit_word | w_way_word[w];
    end
  end

  // Lowest-index invalid way wins; otherwise fall back to the round-robin pointer.
  always_comb begin
    w_victim  = r_ptr[r_idx];
    w_any_inv = 1'b0;
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (!r_valid[r_idx][w]) begin
        w_victim  = WAYW'(w);
        w_any_inv = 1'b1;
      end
    end
  end

  assign w_idle    = (r_state == S_IDLE);
  assign ihit      = w_idle && imemREN && (|w_match);
  assign imemload  = ihit ? w_hit_word : 32'd0;
  assign iREN      = (r_state == S_FETCH);
  assign iaddr     = iREN ? {r_base + 30'(r_cnt), 2'b00} : 32'd0;
  assign w_start   = w_idle && imemREN && !(|w_match) && !flush;
  assign w_install = iREN && !iwait && (r_cnt == LAST) && !flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_idx   <= '0;
      r_ltag  <= '0;
      for (int s = 0; s < NSETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      for (int s = 0; s < NSETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_base  <= w_waddr & ~30'(WORDS - 1);
            r_idx   <= w_idx;
            r_ltag  <= w_tag;
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end
        end
        default: begin
          if (!iwait) begin
            if (r_cnt == LAST) begin
              r_state                    <= S_IDLE;
              r_cnt                      <= '0;
              r_valid[r_idx][w_victim]   <= 1'b1;
              if (!w_any_inv) begin
                r_ptr[r_idx] <= (NWAYS > 1) ? r_ptr[r_idx] + 1'b1 : '0;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  // Storage arrays carry no reset so they can map onto block RAM.
  always_ff @(posedge CLK) begin
    if (iREN && !iwait) begin
      r_fill[r_cnt] <= iload;
    end
    if (w_install) begin
      r_tag[r_idx][w_victim] <= r_ltag;
      for (int k = 0; k < WORDS; k++) begin
        r_data[r_idx][w_victim][k] <= (OFFW'(k) == r_cnt) ? iload : r_fill[k];
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Directed testbench for icache_sa (NSETS=8, NWAYS=2, WORDS=2).
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
module tb_icache_sa;

  localparam int WORDS = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        flush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;

  int checks = 0;
  int errors = 0;

  icache_sa #(.NSETS(8), .NWAYS(2), .WORDS(WORDS)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr), .flush(flush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iload(iload), .iwait(iwait)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40)      return 32'hAAAA0001;
    else if (a == 32'h44) return 32'hAAAA0002;
    else                  return {16'hBBBB, a[15:0]};
  endfunction

  // Memory model: responds to whatever word address the cache presents.
  always_comb iload = mem_word(iaddr);

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [31:0] a);
    imemaddr = a; imemREN = 1'b1; iwait = 1'b0; flush = 1'b0;
    repeat (WORDS + 1) tick();
    $display("fill addr=%h done", a);
  endtask

  task automatic pulse_flush();
    imemREN = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b0; iwait = 1'b0;
    #2;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL reset_ihit got=%b exp=0", ihit); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL reset_iREN got=%b exp=0", iREN); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
    checks++; if (imemload !== 32'h0) begin errors++; $display("FAIL reset_imemload got=%h exp=0", imemload); end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b0;
    tick();
    $display("reset: outputs idle");
  endtask

  task automatic test_cold_miss();
    imemaddr = 32'h40; imemREN = 1'b1; iwait = 1'b0;
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL cold_c0_ihit got=%b exp=0", ihit); end
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin errors++; $display("FAIL cold_c1 iREN=%b iaddr=%h exp 1/00000040", iREN, iaddr); end
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin errors++; $display("FAIL cold_c2 iREN=%b iaddr=%h exp 1/00000044", iREN, iaddr); end
    tick();
    @(negedge CLK);
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0001) begin errors++; $display("FAIL cold_hit40 ihit=%b data=%h exp 1/aaaa0001", ihit, imemload); end
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL cold_c3_iREN got=%b exp=0", iREN); end
    imemaddr = 32'h44;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0002) begin errors++; $display("FAIL cold_hit44 ihit=%b data=%h exp 1/aaaa0002", ihit, imemload); end
    imemREN = 1'b0;
    tick();
    $display("cold miss: 0x40 filled");
  endtask

  task automatic test_wait_stall();
    logic [31:0] exp_a;
    pulse_flush();
    imemaddr = 32'h40; imemREN = 1'b1; iwait = 1'b1;
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL stall_c0_ihit got=%b exp=0", ihit); end
    tick();
    for (int c = 1; c <= 8; c++) begin
      iwait = ((c % 4) != 0);
      exp_a = (c <= 4) ? 32'h40 : 32'h44;
      @(negedge CLK);
      checks++; if (iREN !== 1'b1 || iaddr !== exp_a) begin errors++; $display("FAIL stall_c%0d iREN=%b iaddr=%h exp 1/%h", c, iREN, iaddr, exp_a); end
      checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL stall_c%0d_ihit got=%b exp=0", c, ihit); end
      tick();
    end
    iwait = 1'b0;
    @(negedge CLK);
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0001) begin errors++; $display("FAIL stall_hit40 ihit=%b data=%h exp 1/aaaa0001", ihit, imemload); end
    imemaddr = 32'h44;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0002) begin errors++; $display("FAIL stall_hit44 ihit=%b data=%h exp 1/aaaa0002", ihit, imemload); end
    imemREN = 1'b0;
    tick();
    $display("wait stall: hit on cycle 9");
  endtask

  task automatic test_replacement();
    pulse_flush();
    fill(32'h40);
    fill(32'h80);
    fill(32'hC0);
    @(negedge CLK);
    imemaddr = 32'h80;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB0080) begin errors++; $display("FAIL repl_hit80 ihit=%b data=%h exp 1/bbbb0080", ihit, imemload); end
    imemaddr = 32'hC0;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB00C0) begin errors++; $display("FAIL repl_hitC0 ihit=%b data=%h exp 1/bbbb00c0", ihit, imemload); end
    imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b0 || imemload !== 32'h0) begin errors++; $display("FAIL repl_miss40 ihit=%b data=%h exp 0/0", ihit, imemload); end
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin errors++; $display("FAIL repl_refill iREN=%b iaddr=%h exp 1/00000040", iREN, iaddr); end
    tick();
    tick();
    @(negedge CLK);
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0001) begin errors++; $display("FAIL repl_rehit40 ihit=%b data=%h exp 1/aaaa0001", ihit, imemload); end
    imemaddr = 32'hC0;
    #1;
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL repl_keepC0 ihit=%b exp 1", ihit); end
    imemaddr = 32'h80;
    #1;
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL repl_evict80 ihit=%b exp 0", ihit); end
    imemREN = 1'b0;
    tick();
    $display("replacement: 0xC0 evicted way0, 0x40 evicted way1");
  endtask

  task automatic test_flush();
    fill(32'h40);
    imemaddr = 32'h40; imemREN = 1'b1; flush = 1'b1;
    @(negedge CLK);
    checks++; if (ihit !== 1'b1) begin errors++; $display("FAIL flush_prehit ihit=%b exp 1", ihit); end
    tick();
    flush = 1'b0;
    @(negedge CLK);
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL flush_miss ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h40) begin errors++; $display("FAIL flush_fetch iREN=%b iaddr=%h exp 1/00000040", iREN, iaddr); end
    tick();
    flush = 1'b1;
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h44) begin errors++; $display("FAIL flush_fetch2 iREN=%b iaddr=%h exp 1/00000044", iREN, iaddr); end
    tick();
    flush = 1'b0;
    @(negedge CLK);
    checks++; if (iREN !== 1'b0 || ihit !== 1'b0) begin errors++; $display("FAIL flush_abort iREN=%b ihit=%b exp 0/0", iREN, ihit); end
    imemREN = 1'b0;
    tick();
    imemREN = 1'b1; flush = 1'b1;
    @(negedge CLK);
    checks++; if (ihit !== 1'b0) begin errors++; $display("FAIL flush_idle_ihit got=%b exp 0", ihit); end
    tick();
    flush = 1'b0; imemREN = 1'b0;
    @(negedge CLK);
    checks++; if (iREN !== 1'b0) begin errors++; $display("FAIL flush_suppress iREN=%b exp 0", iREN); end
    tick();
    $display("flush: contents cleared, fetch aborted");
  endtask

  task automatic test_reset_mid_fill();
    imemaddr = 32'h40; imemREN = 1'b1; iwait = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    checks++; if (iaddr !== 32'h44) begin errors++; $display("FAIL rstfill_pre iaddr=%h exp 00000044", iaddr); end
    #1 RST = 1'b1;
    #1;
    checks++; if (iREN !== 1'b0 || ihit !== 1'b0 || iaddr !== 32'h0) begin errors++; $display("FAIL rstfill_async iREN=%b ihit=%b iaddr=%h exp 0/0/0", iREN, ihit, iaddr); end
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL rstfill_after ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    imemREN = 1'b0;
    tick();
    $display("reset mid-fill: partial block discarded");
  endtask

  task automatic test_addr_change();
    imemaddr = 32'h40; imemREN = 1'b1; iwait = 1'b0;
    tick();
    @(negedge CLK);
    checks++; if (iaddr !== 32'h40) begin errors++; $display("FAIL chg_c1 iaddr=%h exp 00000040", iaddr); end
    imemaddr = 32'h100;
    tick();
    @(negedge CLK);
    checks++; if (iaddr !== 32'h44 || ihit !== 1'b0) begin errors++; $display("FAIL chg_c2 iaddr=%h ihit=%b exp 00000044/0", iaddr, ihit); end
    tick();
    @(negedge CLK);
    checks++; if (ihit !== 1'b0 || iREN !== 1'b0) begin errors++; $display("FAIL chg_c3 ihit=%b iREN=%b exp 0/0", ihit, iREN); end
    tick();
    @(negedge CLK);
    checks++; if (iREN !== 1'b1 || iaddr !== 32'h100) begin errors++; $display("FAIL chg_c4 iREN=%b iaddr=%h exp 1/00000100", iREN, iaddr); end
    tick();
    @(negedge CLK);
    checks++; if (iaddr !== 32'h104) begin errors++; $display("FAIL chg_c5 iaddr=%h exp 00000104", iaddr); end
    tick();
    @(negedge CLK);
    checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB0100) begin errors++; $display("FAIL chg_hit100 ihit=%b data=%h exp 1/bbbb0100", ihit, imemload); end
    imemaddr = 32'h104;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hBBBB0104) begin errors++; $display("FAIL chg_hit104 ihit=%b data=%h exp 1/bbbb0104", ihit, imemload); end
    imemaddr = 32'h40;
    #1;
    checks++; if (ihit !== 1'b1 || imemload !== 32'hAAAA0001) begin errors++; $display("FAIL chg_hit40 ihit=%b data=%h exp 1/aaaa0001", ihit, imemload); end
    imemREN = 1'b0;
    tick();
    $display("address change: 0x40 completed, then 0x100 filled");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_wait_stall();
    test_replacement();
    test_flush();
    test_reset_mid_fill();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the single-word direct-mapped icache.
- Sits between the datapath fetch stage and the memory controller instruction channel.
- Adds N-way associativity with round-robin replacement, multi-word blocks filled by a burst of single-word reads, and a one-cycle flush.
- Read-only; no write path.

Parameters:
- NSETS, 8, number of sets; power of 2, ≥2.
- NWAYS, 2, ways per set; power of 2, 1..4.
- WORDS, 2, 32-bit words per block; power of 2, 1..8.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset; one clock; reset is asynchronous and active-high.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits[1:0] ignored.
- flush  in  1  invalidate whole cache.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  requested word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iload  in  32  memory read data.
- iwait  in  1  memory busy; data not yet valid.

Behaviour:
- Address split: [1:0] byte; next log2(WORDS) bits word offset; next log2(NSETS) bits index; remaining upper bits tag.
- Per set and way: valid bit, tag, WORDS data words. Per set: victim pointer of log2(NWAYS) bits.
- Reset (async, any state):
  - All valid bits 0; all victim pointers 0; state IDLE; word counter 0.
  - Outputs: ihit=0, iREN=0, imemload=0, iaddr=0.
  - Data arrays are not reset.
  - A reset during FETCH discards the partial block.
- Hit (combinational, IDLE only): imemREN=1 and some way in the indexed set is valid with a matching tag.
  - ihit=1 in the same cycle; imemload = that way's word at the word offset.
  - Otherwise ihit=0 and imemload=0.
  - Tags are unique per set, so at most one way can match.
- State IDLE:
  - iREN=0, iaddr=0.
  - imemREN=1 and miss and flush=0 → latch the block base address (word offset 0) and set index, counter=0, go FETCH.
- State FETCH:
  - ihit=0 regardless of imemaddr.
  - iREN=1; iaddr = latched base + counter×4.
  - iwait=1 → hold; iaddr stable.
  - iwait=0 → capture iload into the fill buffer at slot counter, counter+1.
  - On the last word (counter=WORDS-1 and iwait=0), on the same edge:
    - write fill buffer plus the last word into the victim way;
    - tag ← latched tag, valid ← 1;
    - go IDLE.
  - Victim = lowest-index invalid way in the set if any. Otherwise victim = set's pointer, and the pointer increments modulo NWAYS.
  - Pointer does not change when an invalid way is used or on hits.
  - imemaddr changes during FETCH are ignored; the latched block completes.
- Miss latency with iwait=0 throughout: miss seen in cycle 0, FETCH for cycles 1..WORDS, hit in cycle WORDS+1 (if imemaddr is held).
- Flush:
  - All valid bits 0 and all victim pointers 0 at the next edge.
  - In FETCH it also aborts: go IDLE, no install, iREN=0 next cycle.
  - flush=1 in IDLE suppresses miss entry that cycle, but the hit output is still computed from pre-flush contents.
- NWAYS=1 degenerates to direct-mapped; the pointer is unused.
- WORDS=1 gives one FETCH word per miss.

Test Plan:
All scenarios use NSETS=8, NWAYS=2, WORDS=2. Address 0x40 maps to tag 1, set 0.
1. Cold miss: imemaddr=0x40 held, imemREN=1, iwait=0, iload 0xAAAA0001 then 0xAAAA0002.
   - Cycles 1–2: iREN=1, iaddr=0x40 then 0x44.
   - Cycle 3: ihit=1, imemload=0xAAAA0001.
   - Then imemaddr=0x44 → ihit=1 same cycle, imemload=0xAAAA0002.
2. Wait stall: repeat scenario 1 with iwait=1 for 3 cycles before each word.
   - iaddr is held at 0x40 for 4 cycles, then 0x44 for 4 cycles.
   - Hit follows on cycle 9; both words are correct.
3. Replacement: fill 0x40 (way0), then 0x80 (tag 2, way1, invalid-first), then 0xC0 (tag 3).
   - 0xC0 evicts way0 (pointer 0→1).
   - Re-request 0x40 → miss; 0x80 still hits; 0x40 refills way1.
4. Flush: after scenario 1, pulse flush one cycle.
   - 0x40 then misses; iREN=1, iaddr=0x40.
   - Flush in the cycle after iaddr=0x40 with iwait=0: iREN=0 next cycle, 0x40 still a miss afterwards.
5. Reset mid-fill: assert RST while iaddr=0x44 in FETCH.
   - iREN=0 and ihit=0 immediately (asynchronously).
   - After release, 0x40 misses.
6. Address change mid-fill: switch imemaddr to 0x100 during FETCH of 0x40.
   - Fill completes for 0x40 (iaddr 0x40, 0x44).
   - 0x100 then misses and fetches 0x100, 0x104.
